// File: rtl/mrsc_pkg.sv
// MRSC code definitions shared by encoder and decoder: 4x4 data matrix protected by
// row, column, diagonal and anti-diagonal parities (16 check bits).
package mrsc_pkg;

    localparam int CODE_W = 32;
    localparam int DATA_W = 16;
    localparam int CHK_W  = 16;

    typedef logic [CODE_W-1:0] mrsc_code_t;
    typedef logic [DATA_W-1:0] mrsc_data_t;
    typedef logic [CHK_W-1:0]  mrsc_syn_t;

    typedef struct packed {
        mrsc_data_t data;
        logic       corrected;
        logic       uncorr;
    } mrsc_res_t;

    // Check-bit signature of data cell (r,c): one bit in each of the row [15:12],
    // column [11:8], diagonal [7:4] and anti-diagonal [3:0] groups.
    function automatic mrsc_syn_t mrsc_bit_syn(input int r, input int c);
        mrsc_syn_t s;
        s = '0;
        s[15 - r]                 = 1'b1;
        s[11 - c]                 = 1'b1;
        s[7 - ((r + c) % 4)]      = 1'b1;
        s[3 - ((c - r + 4) % 4)]  = 1'b1;
        return s;
    endfunction

    function automatic mrsc_syn_t mrsc_check(input mrsc_data_t d);
        mrsc_syn_t chk;
        chk = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (d[15 - 4*r - c]) chk = chk ^ mrsc_bit_syn(r, c);
        return chk;
    endfunction

    // A lone syndrome bit is a check-bit error; an exact cell signature is a data
    // error; anything else cannot be attributed to a single flip.
    function automatic mrsc_res_t mrsc_correct(input mrsc_data_t d, input mrsc_syn_t s);
        mrsc_res_t res;
        logic      found;
        res.data      = d;
        res.corrected = 1'b0;
        res.uncorr    = 1'b0;
        found         = 1'b0;
        if (s != '0) begin
            if ((s & (s - mrsc_syn_t'(1))) == '0) begin
                found = 1'b1;
            end else begin
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        if (s == mrsc_bit_syn(r, c)) begin
                            res.data[15 - 4*r - c] = ~d[15 - 4*r - c];
                            found = 1'b1;
                        end
            end
            res.corrected = found;
            res.uncorr    = ~found;
        end
        return res;
    endfunction

endpackage

// File: rtl/mrsc_syndrome.sv
// Combinational syndrome calculation feeding the decoder's first pipeline stage.
module mrsc_syndrome
    import mrsc_pkg::*;
(
    input  mrsc_code_t code,
    output mrsc_data_t data,
    output mrsc_syn_t  syn
);

    assign data = code[CODE_W-1:CHK_W];
    assign syn  = code[CHK_W-1:0] ^ mrsc_check(code[CODE_W-1:CHK_W]);

endmodule

// File: rtl/mrsc_decoder.sv
// Two-stage MRSC decoder (syndrome, correct) with valid/ready on both sides.
// Define MRSC_DEC_STATS_EN to add saturating corrected/uncorrectable counters.
module mrsc_decoder
    import mrsc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_data,
    output logic              out_corrected,
    output logic              out_uncorr
`ifdef MRSC_DEC_STATS_EN
    ,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
`endif
);

    localparam int STAGES = 2;

    // vld_pipe[0] is the accept strobe; [1] is S1, [2] is the output stage.
    logic [STAGES:0] vld_pipe;
    mrsc_data_t      s1_data, syn_data;
    mrsc_syn_t       s1_syn, syn_val;
    mrsc_res_t       res;
    logic            s2_free;

    mrsc_syndrome u_syndrome (
        .code (in_code),
        .data (syn_data),
        .syn  (syn_val)
    );

    assign s2_free     = !vld_pipe[2] || out_ready;
    assign in_ready    = s2_free || !vld_pipe[1];
    assign vld_pipe[0] = in_valid && in_ready;
    assign res         = mrsc_correct(s1_data, s1_syn);
    assign out_valid   = vld_pipe[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe[STAGES:1] <= '0;
            s1_data            <= '0;
            s1_syn             <= '0;
            out_data           <= '0;
            out_corrected      <= 1'b0;
            out_uncorr         <= 1'b0;
        end else begin
            if (in_ready) begin
                vld_pipe[1] <= vld_pipe[0];
                if (vld_pipe[0]) begin
                    s1_data <= syn_data;
                    s1_syn  <= syn_val;
                end
            end
            // Output registers only reload on a free slot, so they hold while stalled.
            if (s2_free) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    out_data      <= res.data;
                    out_corrected <= res.corrected;
                    out_uncorr    <= res.uncorr;
                end
            end
        end
    end

`ifdef MRSC_DEC_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (out_valid && out_ready) begin
            if (out_corrected && corr_cnt != '1)   corr_cnt   <= corr_cnt + 1'b1;
            if (out_uncorr && uncorr_cnt != '1)    uncorr_cnt <= uncorr_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mrsc_decoder.sv
// Scoreboard bench for mrsc_decoder; an independent parity encoder produces codewords.
module tb_mrsc_decoder;

    typedef struct {
        logic [15:0] d;
        logic        c;
        logic        u;
        int          acc;
        bit          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_code;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_corrected;
    logic        out_uncorr;
`ifdef MRSC_DEC_STATS_EN
    logic [3:0]  corr_cnt;
    logic [3:0]  uncorr_cnt;
`endif

    exp_t        q[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc    = 0;
    bit          bp_win = 0;
    bit          saw_drop = 0;

    mrsc_decoder #(
`ifdef MRSC_DEC_STATS_EN
        .CNT_W(4)
`else
        .CNT_W(16)
`endif
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_code       (in_code),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_corrected (out_corrected),
        .out_uncorr    (out_uncorr)
`ifdef MRSC_DEC_STATS_EN
        ,
        .corr_cnt      (corr_cnt),
        .uncorr_cnt    (uncorr_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Golden encoder: parities written per group, cell (r,c) = d[15-4r-c].
    function automatic logic [31:0] enc(input logic [15:0] d);
        logic [15:0] k;
        k = '0;
        for (int r = 0; r < 4; r++) k[15-r] = ^d[15-4*r -: 4];
        for (int c = 0; c < 4; c++) k[11-c] = d[15-c] ^ d[11-c] ^ d[7-c] ^ d[3-c];
        for (int g = 0; g < 4; g++)
            for (int r = 0; r < 4; r++) begin
                k[7-g] = k[7-g] ^ d[15 - 4*r - ((g - r + 4) % 4)];
                k[3-g] = k[3-g] ^ d[15 - 4*r - ((g + r) % 4)];
            end
        return {d, k};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic send(input logic [31:0] code, input logic [15:0] d, input logic c,
                        input logic u, input bit push, input bit lat);
        int n;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_code  = code;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("send_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        if (push) begin
            e.d = d; e.c = c; e.u = u; e.acc = cyc; e.lat = lat;
            q.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: pops on every handshake; also checks outputs hold while stalled.
    bit          held_valid = 0;
    logic [17:0] held;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            held_valid = 0;
        end else if (out_valid) begin
            if (held_valid) chk("stall_stable", 32'({out_data, out_corrected, out_uncorr}), 32'(held));
            if (!out_ready) begin
                held_valid = 1;
                held = {out_data, out_corrected, out_uncorr};
            end else begin
                held_valid = 0;
                if (q.size() == 0) begin
                    chk("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("data", 32'(out_data), 32'(e.d));
                    chk("corrected", 32'(out_corrected), 32'(e.c));
                    chk("uncorr", 32'(out_uncorr), 32'(e.u));
                    if (e.lat) chk("latency", 32'(cyc - e.acc), 32'd2);
                end
            end
        end
        if (bp_win && !in_ready) saw_drop = 1;
    end

    logic [15:0] clean[4] = '{16'h0000, 16'h80FA, 16'h00FF, 16'h0400};

    initial begin
        int seen;
        rst_n = 1'b0; in_valid = 1'b0; in_code = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_flags", 32'({out_corrected, out_uncorr}), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        foreach (clean[i]) send(enc(clean[i]), clean[i], 1'b0, 1'b0, 1, 1);
        wait_empty();

        send(enc(16'h0000) ^ 32'h8000_0000, 16'h0000, 1'b1, 1'b0, 1, 0);
        for (int i = 0; i < 32; i++)
            send(enc(16'h80FA) ^ (32'h1 << i), 16'h80FA, 1'b1, 1'b0, 1, 0);
        send(enc(16'h00FF) ^ 32'hCC00_0000, 16'hCCFF, 1'b0, 1'b1, 1, 0);
        wait_empty();

        // Back-pressure: out_ready low for cycles 3..6 of the burst.
        bp_win = 1; saw_drop = 0;
        fork
            for (int i = 0; i < 8; i++)
                send(enc(16'h1357 * 16'(i + 1)), 16'h1357 * 16'(i + 1), 1'b0, 1'b0, 1, 0);
            for (int i = 0; i < 12; i++) begin
                @(posedge clk);
                #1 out_ready = !(i >= 3 && i <= 6);
            end
        join
        out_ready = 1'b1;
        wait_empty();
        bp_win = 0;
        chk("in_ready_dropped", 32'(saw_drop), 32'd1);

        // Reset with two words in flight.
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(enc(16'hAAAA), 16'hAAAA, 1'b0, 1'b0, 0, 0);
        send(enc(16'h5555), 16'h5555, 1'b0, 1'b0, 0, 0);
        @(negedge clk);
        chk("inflight_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1 chk("rst_mid_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("no_out_after_rst", 32'(seen), 32'd0);
        send(enc(16'h5A3C), 16'h5A3C, 1'b0, 1'b0, 1, 1);
        wait_empty();

`ifdef MRSC_DEC_STATS_EN
        for (int i = 0; i < 20; i++)
            send(enc(16'h0F0F) ^ (32'h1 << (i % 32)), 16'h0F0F, 1'b1, 1'b0, 1, 0);
        wait_empty();
        chk("corr_cnt_sat", 32'(corr_cnt), 32'hF);
`endif

        chk("queue_empty_end", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
